volume_meter_multi: RTL and testbench

//  Multi-channel OLED volume meter renderer for the 96x64 display: NUM_CH vertical segment bars.

---
 rtl/volume_meter_pkg.sv | 35 +++
 rtl/volume_meter_multi_channel.sv | 75 +++++++
 rtl/volume_meter_multi.sv | 143 ++++++++++++++
 tb/tb_volume_meter_multi.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/volume_meter_pkg.sv
// Shared constants for the multi-channel OLED volume meter: display geometry,
// RGB565 palette, colour-band type and border-width decode.
package volume_meter_pkg;

    localparam int OLED_W    = 96;
    localparam int OLED_H    = 64;
    localparam int SEG_PITCH = 4;

    localparam logic [15:0] C_BLACK    = 16'h0000;
    localparam logic [15:0] C_WHITE    = 16'hFFFF;
    localparam logic [15:0] C_GREEN    = 16'h07E0;
    localparam logic [15:0] C_YELLOW   = 16'hFFE0;
    localparam logic [15:0] C_RED      = 16'hF800;
    localparam logic [15:0] C_INV_LOW  = 16'h7CDF;
    localparam logic [15:0] C_INV_MID  = 16'hC3FF;
    localparam logic [15:0] C_INV_HIGH = 16'hFBFA;

    typedef enum logic [1:0] {
        BAND_LOW  = 2'd0,
        BAND_MID  = 2'd1,
        BAND_HIGH = 2'd2
    } band_e;

    // mode[1] enables the border, mode[0] selects the thick variant
    function automatic logic [7:0] border_width(input logic [1:0] mode);
        logic [7:0] w;
        case (mode)
            2'b10:   w = 8'd1;
            2'b11:   w = 8'd3;
            default: w = 8'd0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/volume_meter_multi_channel.sv
// meter_channel: per-channel level smoothing (instant attack, timed decay) and,
// when VOLUME_METER_PEAK_HOLD_EN is defined, a held/decaying peak level.
module meter_channel #(
    parameter int LEVEL_W      = 4,
    parameter int DECAY_FRAMES = 4,
    parameter int PEAK_HOLD    = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic [LEVEL_W-1:0] raw,
    output logic [LEVEL_W-1:0] disp_lvl,
    output logic [LEVEL_W-1:0] peak_lvl
);
    localparam int                 DCW        = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
    localparam logic [DCW-1:0]     DECAY_LAST = DCW'(DECAY_FRAMES - 1);
    localparam logic [DCW-1:0]     ONE_D      = DCW'(1);
    localparam logic [LEVEL_W-1:0] ONE_L      = LEVEL_W'(1);

    logic [LEVEL_W-1:0] disp_r;
    logic [DCW-1:0]     decay_cnt_r;

    // Displayed level: jump up to raw, otherwise step down once per DECAY_FRAMES frames
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_r      <= '0;
            decay_cnt_r <= '0;
        end else if (frame_tick) begin
            if (raw > disp_r) begin
                disp_r      <= raw;
                decay_cnt_r <= '0;
            end else if (decay_cnt_r == DECAY_LAST) begin
                decay_cnt_r <= '0;
                if (disp_r != '0) begin
                    disp_r <= disp_r - ONE_L;
                end
            end else begin
                decay_cnt_r <= decay_cnt_r + ONE_D;
            end
        end
    end

    assign disp_lvl = disp_r;

`ifdef VOLUME_METER_PEAK_HOLD_EN
    localparam int            HW     = $clog2(PEAK_HOLD + 1);
    localparam logic [HW-1:0] HOLD_V = HW'(PEAK_HOLD);
    localparam logic [HW-1:0] ONE_H  = HW'(1);

    logic [LEVEL_W-1:0] peak_r;
    logic [HW-1:0]      hold_r;

    // Peak follows raw upward, holds, then sinks one segment per frame towards disp
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_r <= '0;
            hold_r <= '0;
        end else if (frame_tick) begin
            if (raw >= peak_r) begin
                peak_r <= raw;
                hold_r <= HOLD_V;
            end else if (hold_r != '0) begin
                hold_r <= hold_r - ONE_H;
            end else if (peak_r > disp_r) begin
                peak_r <= peak_r - ONE_L;
            end
        end
    end

    assign peak_lvl = peak_r;
`else
    assign peak_lvl = '0;
`endif

endmodule

// File: rtl/volume_meter_multi.sv
// Multi-channel OLED volume meter: movable bar positions, pixel compositor and
// registered RGB565 output. Peak marker built only with VOLUME_METER_PEAK_HOLD_EN.
module volume_meter_multi
    import volume_meter_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int LEVEL_W      = 4,
    parameter int BAR_W        = 10,
    parameter int STEP         = 5,
    parameter int X0           = 43,
    parameter int CH_SPACING   = 14,
    parameter int LOW_MAX      = 4,
    parameter int MID_MAX      = 10,
    parameter int DECAY_FRAMES = 4,
    parameter int PEAK_HOLD    = 30
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_tick,
    input  logic [NUM_CH*LEVEL_W-1:0] mic_level,
    input  logic [6:0]                x,
    input  logic [5:0]                y,
    input  logic                      btn_l,
    input  logic                      btn_r,
    input  logic [1:0]                sel_ch,
    input  logic                      move_en,
    input  logic                      recentre,
    input  logic [1:0]                border_mode,
    input  logic                      invert,
    input  logic                      blank,
    output logic [15:0]               colour
);
    localparam logic [7:0] STEP_8    = 8'(STEP);
    localparam logic [7:0] BAR_W_8   = 8'(BAR_W);
    localparam logic [7:0] LOW_MAX_8 = 8'(LOW_MAX);
    localparam logic [7:0] MID_MAX_8 = 8'(MID_MAX);
    localparam logic [7:0] SEG_MAX_8 = 8'(2**LEVEL_W - 1);
    localparam logic [7:0] X_LAST_8  = 8'(OLED_W - 1);
    localparam logic [7:0] Y_LAST_8  = 8'(OLED_H - 1);

    logic [LEVEL_W-1:0] disp_s [NUM_CH];
    logic [LEVEL_W-1:0] peak_s [NUM_CH];
    logic [7:0]         pos_r  [NUM_CH];
    logic [7:0]         bw_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        meter_channel #(
            .LEVEL_W      (LEVEL_W),
            .DECAY_FRAMES (DECAY_FRAMES),
            .PEAK_HOLD    (PEAK_HOLD)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .frame_tick (frame_tick),
            .raw        (mic_level[g*LEVEL_W +: LEVEL_W]),
            .disp_lvl   (disp_s[g]),
            .peak_lvl   (peak_s[g])
        );
    end

    assign bw_s = border_width(border_mode);

    // Bar X positions; a move is dropped whenever it would push the bar into the border
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!rst_n || recentre) begin
                pos_r[i] <= 8'(X0 + i * CH_SPACING);
            end else if (move_en && (sel_ch == 2'(i)) && (btn_l != btn_r)) begin
                if (btn_l && (pos_r[i] > bw_s + STEP_8)) begin
                    pos_r[i] <= pos_r[i] - STEP_8;
                end else if (btn_r && (pos_r[i] + bw_s + BAR_W_8 + STEP_8 <= X_LAST_8)) begin
                    pos_r[i] <= pos_r[i] + STEP_8;
                end
            end
        end
    end

    logic [7:0]        x8_s, y8_s, seg_s;
    logic [6:0]        dist_s;
    logic              seg_ok_s, border_s;
    logic [15:0]       seg_col_s, bg_s, fg_s, bar_s, pix_s;
    logic [NUM_CH-1:0] cover_s;
    logic [15:0]       ch_pix_s [NUM_CH];
    band_e             band_s;

    // Pixel compositor; segment k spans rows H-2-4k..H-4k, row H-3-4k is the gap
    always_comb begin
        x8_s     = {1'b0, x};
        y8_s     = {2'b00, y};
        dist_s   = 7'(OLED_H) - {1'b0, y};
        seg_s    = {3'b000, dist_s[6:2]};
        seg_ok_s = (dist_s[1:0] != 2'b11) && (seg_s != 8'd0) && (seg_s <= SEG_MAX_8);
        border_s = (x8_s < bw_s) || (x8_s > X_LAST_8 - bw_s) ||
                   (y8_s < bw_s) || (y8_s > Y_LAST_8 - bw_s);
        bg_s     = invert ? C_WHITE : C_BLACK;
        fg_s     = invert ? C_BLACK : C_WHITE;

        if (seg_s <= LOW_MAX_8) begin
            band_s = BAND_LOW;
        end else if (seg_s <= MID_MAX_8) begin
            band_s = BAND_MID;
        end else begin
            band_s = BAND_HIGH;
        end

        case (band_s)
            BAND_LOW: seg_col_s = invert ? C_INV_LOW : C_GREEN;
            BAND_MID: seg_col_s = invert ? C_INV_MID : C_YELLOW;
            default:  seg_col_s = invert ? C_INV_HIGH : C_RED;
        endcase

        for (int i = 0; i < NUM_CH; i++) begin
            cover_s[i]  = (x8_s >= pos_r[i]) && (x8_s < pos_r[i] + BAR_W_8);
            ch_pix_s[i] = (seg_ok_s && (seg_s <= 8'(disp_s[i]))) ? seg_col_s :
                          (seg_ok_s && (peak_s[i] != '0) && (seg_s == 8'(peak_s[i]))) ? fg_s :
                          bg_s;
        end

        // Walk downwards so the lowest covering channel is written last and wins
        bar_s = bg_s;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            bar_s = cover_s[i] ? ch_pix_s[i] : bar_s;
        end

        if (border_s) begin
            pix_s = fg_s;
        end else if (blank) begin
            pix_s = bg_s;
        end else begin
            pix_s = bar_s;
        end
    end

    // Registered pixel output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            colour <= 16'h0000;
        end else begin
            colour <= pix_s;
        end
    end

endmodule

// File: tb/tb_volume_meter_multi.sv
// Directed, table-driven bench for volume_meter_multi (default parameters).
module tb_volume_meter_multi;

`ifdef VOLUME_METER_PEAK_HOLD_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif
    localparam logic [15:0] MK = PEAK_ON ? 16'hFFFF : 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n, frame_tick, btn_l, btn_r, move_en, recentre, invert, blank;
    logic [7:0]  mic_level;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [1:0]  sel_ch, border_mode;
    logic [15:0] colour;

    int n_vec = 0;
    int n_err = 0;

    volume_meter_multi dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .mic_level(mic_level),
        .x(x), .y(y), .btn_l(btn_l), .btn_r(btn_r), .sel_ch(sel_ch), .move_en(move_en),
        .recentre(recentre), .border_mode(border_mode), .invert(invert), .blank(blank),
        .colour(colour)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  px;
        logic [5:0]  py;
        logic [1:0]  bm;
        logic        inv;
        logic        blk;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [32];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: colour=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic probe(input int px, input int py, input string nm, input logic [15:0] exp);
        x = 7'(px);
        y = 6'(py);
        @(posedge clk);
        #1;
        check($sformatf("%s(%0d,%0d)", nm, px, py), colour, exp);
    endtask

    task automatic tick_frame();
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_frame();
    endtask

    task automatic press(input logic l, input logic r);
        btn_l = l;
        btn_r = r;
        @(posedge clk);
        #1;
        btn_l = 1'b0;
        btn_r = 1'b0;
    endtask

    task automatic pulse_recentre();
        recentre = 1'b1;
        @(posedge clk);
        #1;
        recentre = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_pos;

        // px, py, border_mode, invert, blank, expected
        tbl[0]  = '{7'd45, 6'd3,  2'b00, 1'b0, 1'b0, 16'hF800};
        tbl[1]  = '{7'd45, 6'd20, 2'b00, 1'b0, 1'b0, 16'hF800};
        tbl[2]  = '{7'd45, 6'd22, 2'b00, 1'b0, 1'b0, 16'hFFE0};
        tbl[3]  = '{7'd45, 6'd40, 2'b00, 1'b0, 1'b0, 16'hFFE0};
        tbl[4]  = '{7'd45, 6'd42, 2'b00, 1'b0, 1'b0, 16'hFFE0};
        tbl[5]  = '{7'd45, 6'd46, 2'b00, 1'b0, 1'b0, 16'h07E0};
        tbl[6]  = '{7'd45, 6'd61, 2'b00, 1'b0, 1'b0, 16'h0000};
        tbl[7]  = '{7'd45, 6'd57, 2'b00, 1'b0, 1'b0, 16'h0000};
        tbl[8]  = '{7'd42, 6'd3,  2'b00, 1'b0, 1'b0, 16'h0000};
        tbl[9]  = '{7'd53, 6'd3,  2'b00, 1'b0, 1'b0, 16'h0000};
        tbl[10] = '{7'd52, 6'd3,  2'b00, 1'b0, 1'b0, 16'hF800};
        tbl[11] = '{7'd60, 6'd42, 2'b00, 1'b0, 1'b0, 16'hFFE0};
        tbl[12] = '{7'd60, 6'd38, 2'b00, 1'b0, 1'b0, 16'h0000};
        tbl[13] = '{7'd60, 6'd58, 2'b00, 1'b0, 1'b0, 16'h07E0};
        tbl[14] = '{7'd0,  6'd30, 2'b10, 1'b0, 1'b0, 16'hFFFF};
        tbl[15] = '{7'd1,  6'd30, 2'b10, 1'b0, 1'b0, 16'h0000};
        tbl[16] = '{7'd95, 6'd30, 2'b10, 1'b0, 1'b0, 16'hFFFF};
        tbl[17] = '{7'd2,  6'd30, 2'b11, 1'b0, 1'b0, 16'hFFFF};
        tbl[18] = '{7'd3,  6'd30, 2'b11, 1'b0, 1'b0, 16'h0000};
        tbl[19] = '{7'd93, 6'd30, 2'b11, 1'b0, 1'b0, 16'hFFFF};
        tbl[20] = '{7'd60, 6'd61, 2'b11, 1'b0, 1'b0, 16'hFFFF};
        tbl[21] = '{7'd45, 6'd2,  2'b11, 1'b0, 1'b0, 16'hFFFF};
        tbl[22] = '{7'd45, 6'd2,  2'b00, 1'b0, 1'b0, 16'hF800};
        tbl[23] = '{7'd45, 6'd3,  2'b00, 1'b1, 1'b0, 16'hFBFA};
        tbl[24] = '{7'd45, 6'd22, 2'b00, 1'b1, 1'b0, 16'hC3FF};
        tbl[25] = '{7'd45, 6'd46, 2'b00, 1'b1, 1'b0, 16'h7CDF};
        tbl[26] = '{7'd45, 6'd61, 2'b00, 1'b1, 1'b0, 16'hFFFF};
        tbl[27] = '{7'd1,  6'd1,  2'b11, 1'b1, 1'b0, 16'h0000};
        tbl[28] = '{7'd45, 6'd3,  2'b00, 1'b0, 1'b1, 16'h0000};
        tbl[29] = '{7'd45, 6'd3,  2'b00, 1'b1, 1'b1, 16'hFFFF};
        tbl[30] = '{7'd1,  6'd1,  2'b11, 1'b0, 1'b1, 16'hFFFF};
        tbl[31] = '{7'd60, 6'd42, 2'b00, 1'b1, 1'b0, 16'hC3FF};

        rst_n = 1'b0; frame_tick = 1'b0; btn_l = 1'b0; btn_r = 1'b0; move_en = 1'b0;
        recentre = 1'b0; invert = 1'b0; blank = 1'b0; mic_level = 8'h00;
        x = 7'd45; y = 6'd58; sel_ch = 2'd0; border_mode = 2'b00;

        // Reset state
        do_reset();
        check("reset_colour", colour, 16'h0000);
        probe(45, 58, "reset_level0", 16'h0000);
        probe(60, 58, "reset_level1", 16'h0000);

        // Table: ch0 at 15, ch1 at 5, default positions 43 / 57
        mic_level = {4'd5, 4'd15};
        tick_frame();
        for (int i = 0; i < 32; i++) begin
            border_mode = tbl[i].bm;
            invert      = tbl[i].inv;
            blank       = tbl[i].blk;
            probe(tbl[i].px, tbl[i].py, $sformatf("vec%0d", i), tbl[i].exp);
        end
        border_mode = 2'b00; invert = 1'b0; blank = 1'b0;

        // Decay: 15 holds for three frames, drops to 14 on the fourth
        mic_level = 8'h00;
        ticks(3);
        probe(45, 3, "decay_hold", 16'hF800);
        tick_frame();
        probe(45, 3, "decay_top", MK);
        probe(45, 7, "decay_14", 16'hF800);

        // Peak hold and fall
        do_reset();
        mic_level = {4'd0, 4'd12};
        tick_frame();
        mic_level = 8'h00;
        ticks(30);
        probe(45, 15, "peak_held", MK);
        probe(45, 43, "level_after30", 16'hFFE0);
        probe(45, 39, "level_above", 16'h0000);
        tick_frame();
        probe(45, 15, "peak_left12", 16'h0000);
        probe(45, 19, "peak_at11", MK);
        tick_frame();
        probe(45, 19, "peak_left11", 16'h0000);
        probe(45, 23, "peak_at10", MK);
        probe(45, 43, "level_after32", 16'h0000);

        // Movement with thick border (bw=3)
        do_reset();
        mic_level = {4'd0, 4'd15};
        tick_frame();
        border_mode = 2'b11;
        move_en = 1'b1;
        sel_ch = 2'd0;
        exp_pos = 43;
        probe(exp_pos, 3, "pos_start", 16'hF800);
        for (int i = 0; i < 8; i++) begin
            press(1'b1, 1'b0);
            if (exp_pos > 3 + 5) exp_pos -= 5;
            probe(exp_pos, 3, "move_l_in", 16'hF800);
            probe(exp_pos - 1, 3, "move_l_out", 16'h0000);
        end
        for (int i = 0; i < 15; i++) begin
            press(1'b0, 1'b1);
            if (exp_pos <= 95 - 3 - 10 - 5) exp_pos += 5;
            probe(exp_pos, 3, "move_r_in", 16'hF800);
            probe(exp_pos + 10, 3, "move_r_out", 16'h0000);
        end
        press(1'b1, 1'b1);
        probe(78, 3, "both_btn", 16'hF800);
        probe(77, 3, "both_btn_out", 16'h0000);
        move_en = 1'b0;
        press(1'b1, 1'b0);
        probe(78, 3, "move_dis", 16'hF800);
        move_en = 1'b1;
        sel_ch = 2'd2;
        press(1'b1, 1'b0);
        probe(78, 3, "sel_invalid", 16'hF800);
        probe(77, 3, "sel_invalid_out", 16'h0000);

        // Overlap and recentre
        mic_level = {4'd15, 4'd15};
        tick_frame();
        pulse_recentre();
        probe(43, 3, "recentre0", 16'hF800);
        probe(42, 3, "recentre0_out", 16'h0000);
        probe(66, 3, "recentre1", 16'hF800);
        probe(67, 3, "recentre1_out", 16'h0000);
        sel_ch = 2'd1;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        probe(50, 3, "overlap", 16'hF800);
        probe(56, 3, "overlap_ch1", 16'hF800);
        probe(57, 3, "overlap_out", 16'h0000);
        pulse_recentre();
        probe(57, 3, "recentre_again", 16'hF800);
        probe(53, 3, "recentre_gap", 16'h0000);

        // Inverted, level 0
        do_reset();
        border_mode = 2'b11;
        invert = 1'b1;
        probe(1, 1, "inv_border", 16'h0000);
        probe(48, 40, "inv_bg", 16'hFFFF);
        border_mode = 2'b00;
        invert = 1'b0;

        // Reset mid-frame
        mic_level = {4'd0, 4'd15};
        tick_frame();
        probe(45, 3, "pre_reset", 16'hF800);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_colour", colour, 16'h0000);
        rst_n = 1'b1;
        mic_level = 8'h00;
        probe(45, 3, "post_reset", 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
